code_decoder: RTL and testbench
===============================

CODE_DECODER -- requirements
Module: code_decoder

Interface
REQ-001 Parameter HOLD, default 2, SHALL set the number of cycles each decoded one-hot word is driven (legal range 1..255).
REQ-002 Parameter CNT_W, default 8, SHALL set the width of each per-line event counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL indicate that in_code carries a code to decode.
REQ-006 in_code  input  2  SHALL be the binary code to decode (0..3).
REQ-007 in_ready  output  1  SHALL indicate the block can accept a code this cycle.
REQ-008 y  output  4  SHALL be the one-hot decoded word (bit n set for code n), all-zero when idle.
REQ-009 y_valid  output  1  SHALL be high exactly while y is non-zero.
REQ-010 busy  output  1  SHALL be high when the FSM is in DRIVE or the FIFO is non-empty.
REQ-011 cnt_sel  input  2  SHALL select which per-line counter appears on cnt_out.
REQ-012 cnt_out  output  CNT_W  SHALL show the selected counter combinationally from registered state.
REQ-013 clr_cnt  input  1  SHALL synchronously clear all four counters.

Function
REQ-014 Input SHALL be buffered in a 2-entry FIFO; in_ready = FIFO not full.
REQ-015 Transfer SHALL occur only on a rising edge with in_valid=1 and in_ready=1; in_code is written to the FIFO tail.
REQ-016 When the FIFO is full, in_ready SHALL be 0 even if a pop happens in the same cycle (no push-through when full).
REQ-017 Push and pop in the same cycle with the FIFO not full SHALL both take effect; occupancy is unchanged.
REQ-018 The FSM SHALL have two states: IDLE, DRIVE.
REQ-019 In IDLE with FIFO non-empty, the FSM SHALL pop the head, load y = 1<<code, load hold counter = HOLD-1, and enter DRIVE.
REQ-020 In DRIVE with hold counter > 0, it SHALL decrement the hold counter and keep y stable.
REQ-021 In DRIVE with hold counter = 0 and FIFO non-empty, it SHALL pop the next code and load y/hold counter with no idle gap.
REQ-022 In DRIVE with hold counter = 0 and FIFO empty, it SHALL clear y to 0 and return to IDLE.
REQ-023 Latency: a code accepted on edge k into an empty FIFO while IDLE SHALL appear on y after edge k+1 and hold for exactly HOLD cycles.
REQ-024 Counter n SHALL increment by 1 on each edge where code n is loaded into y.
REQ-025 Counters SHALL saturate at 2^CNT_W-1 (no wrap-around).
REQ-026 clr_cnt SHALL take priority over a same-cycle increment; the counter reads 0 afterwards.
REQ-027 in_code SHALL be ignored when in_valid=0; no illegal code exists (all 4 values decode).

Reset
REQ-028 rst_n low SHALL immediately clear: FIFO (empty), FSM to IDLE, hold counter 0, y=0, y_valid=0, busy=0, all counters 0; in_ready=1 after reset.
REQ-029 Reset asserted mid-DRIVE SHALL drop y to 0 without completing the hold period; buffered codes are discarded.
REQ-030 After rst_n deasserts, the first rising edge SHALL accept input normally.

Verification
REQ-031 HOLD=2; push code 2 once -> y=4'b0100, y_valid=1 for exactly 2 cycles starting one cycle after acceptance, then y=0; cnt_sel=2 shows 1.
REQ-032 HOLD=2; push codes 0,3,1 back-to-back with in_valid held high -> y sequence 0001,0001,1000,1000,0010,0010 with no gap; in_ready=0 on the cycle the FIFO holds 2 entries.
REQ-033 HOLD=1; hold in_valid=1 with code 3 for 300 cycles, CNT_W=8 -> counter 3 saturates at 255.
REQ-034 Assert clr_cnt on the same edge that code 1 loads -> counter 1 reads 0 afterwards.
REQ-035 HOLD=4; assert rst_n=0 during cycle 2 of DRIVE with 2 codes queued -> y=0, busy=0, in_ready=1 immediately; no queued code appears after reset release.
REQ-036 FIFO full with in_valid=1 -> no acceptance until the cycle after a pop; no code lost or duplicated (scoreboard check).

Source files
------------

// File: rtl/code_decoder_if.sv
// Handshake and status bundle for code_decoder: code input, one-hot output, counter readout.
interface code_decoder_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             in_valid;
    logic [1:0]       in_code;
    logic             in_ready;
    logic [3:0]       y;
    logic             y_valid;
    logic             busy;
    logic [1:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_out;
    logic             clr_cnt;

    // Producer side: supplies codes and counter controls.
    modport master (
        output in_valid, in_code, cnt_sel, clr_cnt,
        input  in_ready, y, y_valid, busy, cnt_out
    );

    // Decoder side.
    modport slave (
        input  in_valid, in_code, cnt_sel, clr_cnt,
        output in_ready, y, y_valid, busy, cnt_out
    );
endinterface

// File: rtl/code_decoder.sv
// 2-to-4 one-hot decoder fed by a 2-entry FIFO; each decoded word is held for HOLD cycles
// and back-to-back codes follow each other without an idle gap. Per-line saturating
// counters record how often each code was loaded.
module code_decoder #(
    parameter int unsigned HOLD  = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    code_decoder_if.slave bus
);

    localparam logic StIdle  = 1'b0;
    localparam logic StDrive = 1'b1;

    localparam logic [7:0]       HoldInit = 8'(HOLD - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    // FIFO storage and bookkeeping
    logic [1:0] fifo_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] head;
    logic       empty;
    logic       in_ready;
    logic       push;
    logic       pop;

    // Decoder FSM state
    logic       state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] y_q, y_d;

    logic [CNT_W-1:0] cnt_q [4];

    // A full FIFO never accepts, even when the FSM pops in the same cycle.
    assign in_ready = (count_q != 2'd2);
    assign empty    = (count_q == 2'd0);
    assign push     = bus.in_valid && in_ready;
    assign head     = fifo_q[rd_ptr_q];

    // Next-state for the hold/drive sequencer; pop marks a load of the FIFO head into y.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        y_d     = y_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    y_d     = 4'b0001 << head;
                    hold_d  = HoldInit;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                if (hold_q != 8'd0) begin
                    hold_d = hold_q - 8'd1;
                end else if (!empty) begin
                    pop    = 1'b1;
                    y_d    = 4'b0001 << head;
                    hold_d = HoldInit;
                end else begin
                    y_d     = 4'b0000;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO write, read pointer advance and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= 2'd0;
            fifo_q[1] <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= bus.in_code;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push && !pop) begin
                count_q <= count_q + 2'd1;
            end else if (pop && !push) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

    // FSM, hold counter and output word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hold_q  <= 8'd0;
            y_q     <= 4'b0000;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            y_q     <= y_d;
        end
    end

    // Saturating per-line load counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.clr_cnt) begin
                    cnt_q[i] <= '0;
                end else if (pop && (head == 2'(i)) && (cnt_q[i] != CntMax)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.y        = y_q;
    assign bus.y_valid  = |y_q;
    assign bus.busy     = (state_q == StDrive) || !empty;
    assign bus.cnt_out  = cnt_q[bus.cnt_sel];

endmodule

// File: tb/tb_code_decoder.sv
// Scoreboard bench for code_decoder: the driver queues accepted codes, a negedge monitor
// advances a behavioural model one edge at a time and compares every DUT output.
module tb_code_decoder;

    localparam int unsigned HOLD   = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int          CntMax = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    code_decoder_if #(.CNT_W(CNT_W)) bus ();

    code_decoder #(
        .HOLD  (HOLD),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: codes waiting in the FIFO, codes accepted on the coming edge,
    // the word currently shown and how many more cycles it stays, and load tallies.
    int   pending[$];
    int   acc_q[$];
    int   cur_left = 0;
    int   cur_code = 0;
    int   counts[4];
    logic clr_now  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pending.delete();
        acc_q.delete();
        cur_left = 0;
        cur_code = 0;
        for (int i = 0; i < 4; i++) counts[i] = 0;
        clr_now = 1'b0;
    endtask

    // One clock of stimulus; returns y and in_ready as seen just before the new inputs.
    task automatic step(input logic v, input logic [1:0] c, input logic clr,
                        input logic [1:0] sel, output logic [3:0] y_obs, output logic rdy_obs);
        @(negedge clk);
        y_obs   = bus.y;
        rdy_obs = bus.in_ready;
        #2;
        bus.in_valid = v;
        bus.in_code  = v ? c : 2'($urandom_range(0, 3));
        bus.clr_cnt  = clr;
        bus.cnt_sel  = sel;
        clr_now      = clr;
        if (v && (pending.size() < 2)) acc_q.push_back(int'(c));
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        #2;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.clr_cnt  = 1'b0;
        model_reset();
        #1;
        chk("rst_y", int'(bus.y), 0);
        chk("rst_y_valid", int'(bus.y_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_cnt_out", int'(bus.cnt_out), 0);
        repeat (cycles) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: apply the decoder rules for the edge just passed, then compare.
    always @(negedge clk) begin
        int  exp_y;
        logic load;
        if (rst_n) begin
            load = 1'b0;
            if (cur_left > 1) begin
                cur_left--;
            end else if (pending.size() > 0) begin
                cur_code = pending.pop_front();
                cur_left = HOLD;
                load     = 1'b1;
            end else begin
                cur_left = 0;
            end
            if (clr_now) begin
                for (int i = 0; i < 4; i++) counts[i] = 0;
            end else if (load && counts[cur_code] < CntMax) begin
                counts[cur_code]++;
            end
            while (acc_q.size() > 0) pending.push_back(acc_q.pop_front());
            exp_y = (cur_left > 0) ? (1 << cur_code) : 0;
            chk("mon_y", int'(bus.y), exp_y);
            chk("mon_y_valid", int'(bus.y_valid), int'(exp_y != 0));
            chk("mon_busy", int'(bus.busy), int'((cur_left > 0) || (pending.size() > 0)));
            chk("mon_in_ready", int'(bus.in_ready), int'(pending.size() < 2));
            chk("mon_cnt_out", int'(bus.cnt_out), counts[bus.cnt_sel]);
        end
    end

    initial begin
        logic [3:0] obs_y [10];
        logic       obs_r [10];
        logic [3:0] yo;
        logic       ro;
        int         exp_seq [7];
        int         codes [3];

        bus.in_valid = 1'b0;
        bus.in_code  = 2'd0;
        bus.clr_cnt  = 1'b0;
        bus.cnt_sel  = 2'd0;
        model_reset();

        // Reset state
        #1;
        chk("init_y", int'(bus.y), 0);
        chk("init_busy", int'(bus.busy), 0);
        chk("init_in_ready", int'(bus.in_ready), 1);
        chk("init_cnt_out", int'(bus.cnt_out), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Single code 2: one idle cycle, then 0100 for HOLD cycles, then idle.
        step(1'b1, 2'd2, 1'b0, 2'd2, yo, ro);
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 1'b0, 2'd2, obs_y[i], obs_r[i]);
        chk("single_lat", int'(obs_y[0]), 0);
        chk("single_h1", int'(obs_y[1]), 4);
        chk("single_h2", int'(obs_y[2]), 4);
        chk("single_end", int'(obs_y[3]), 0);
        chk("single_cnt2", int'(bus.cnt_out), 1);

        // Back-to-back 0,3,1 with no gap; FIFO fills on the third push.
        codes   = '{0, 3, 1};
        exp_seq = '{1, 1, 8, 8, 2, 2, 0};
        for (int i = 0; i < 3; i++) step(1'b1, 2'(codes[i]), 1'b0, 2'd0, obs_y[i], obs_r[i]);
        for (int i = 3; i < 10; i++) step(1'b0, 2'd0, 1'b0, 2'd0, obs_y[i], obs_r[i]);
        for (int i = 0; i < 7; i++) chk("b2b_seq", int'(obs_y[i + 2]), exp_seq[i]);
        chk("b2b_full_ready", int'(obs_r[3]), 0);
        chk("b2b_after_pop_ready", int'(obs_r[4]), 1);

        // Clear on the same edge that code 1 loads.
        step(1'b1, 2'd1, 1'b0, 2'd1, yo, ro);
        step(1'b0, 2'd0, 1'b1, 2'd1, yo, ro);
        step(1'b0, 2'd0, 1'b0, 2'd1, yo, ro);
        chk("clr_prio_y", int'(yo), 2);
        chk("clr_prio_cnt1", int'(bus.cnt_out), 0);
        repeat (4) step(1'b0, 2'd0, 1'b0, 2'd1, yo, ro);

        // Reset in the second DRIVE cycle with two codes queued; nothing resurfaces.
        step(1'b1, 2'd0, 1'b0, 2'd0, yo, ro);
        step(1'b1, 2'd1, 1'b0, 2'd0, yo, ro);
        step(1'b1, 2'd2, 1'b0, 2'd0, yo, ro);
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 2'd0, 1'b0, 2'($urandom_range(0, 3)), yo, ro);
            chk("post_rst_idle", int'(yo), 0);
        end

        // Continuous code 3 with FIFO pressure; counter 3 must pin at its maximum.
        repeat (600) step(1'b1, 2'd3, 1'b0, 2'd3, yo, ro);
        repeat (8) step(1'b0, 2'd0, 1'b0, 2'd3, yo, ro);
        chk("sat_cnt3", int'(bus.cnt_out), CntMax);

        // Random traffic with occasional clears and one reset in the middle.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset(1);
            step(logic'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 logic'($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)), yo, ro);
        end
        repeat (10) step(1'b0, 2'd0, 1'b0, 2'($urandom_range(0, 3)), yo, ro);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
